// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling FSM, FWFT byte FIFO
// with sticky framing and overrun flags.
module uart_rx #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_en_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  input  logic                  err_clr_i
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e                state_q, state_d;
  logic [1:0]            sync_q;
  logic                  prev_q;
  logic                  rx_s;
  logic [15:0]           baud_q, baud_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  push_req, ferr_set;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ferr_q, ferr_d, ovr_q, ovr_d;
  logic                  full, do_push, do_pop, ovr_set;
  logic [15:0]           half_last, bit_last;

  assign rx_s      = sync_q[1];
  assign half_last = (baud_div_i >> 1) - 16'd1;
  assign bit_last  = baud_div_i - 16'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      sync_q  <= {sync_q[0], rx_bit_i};
      prev_q  <= rx_s;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    push_req = 1'b0;
    ferr_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_en_i && prev_q && !rx_s) begin
          state_d = START;
          baud_d  = '0;
        end
      end
      START: begin
        if (baud_q == half_last) begin
          if (!rx_s) begin
            state_d = DATA;
            baud_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_q == bit_last) begin
          shift_d[bit_q] = rx_s;
          baud_d         = '0;
          if (bit_q == BW'(DATA_WIDTH - 1)) state_d = STOP;
          else                              bit_d   = bit_q + BW'(1);
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_q == bit_last) begin
          if (rx_s) push_req = 1'b1;
          else      ferr_set = 1'b1;
          state_d = IDLE;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign full    = (count_q == CW'(FIFO_DEPTH));
  assign do_pop  = rx_re_i && (count_q != '0);
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;
  assign rd_nxt  = rd_ptr_q + AW'(1);

  // Head register is reloaded from the slot behind the popped one, or bypassed
  // from the incoming byte when that byte becomes the new head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_nxt;
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
    if (do_pop) begin
      if (count_q > CW'(1)) dout_d = mem[rd_nxt];
      else if (do_push)     dout_d = shift_q;
    end else if (do_push && count_q == '0) begin
      dout_d = shift_q;
    end
    ferr_d = ferr_set | (ferr_q & ~err_clr_i);
    ovr_d  = ovr_set  | (ovr_q  & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= shift_q;
  end

  assign dout_o      = dout_q;
  assign empty_o     = (count_q == '0);
  assign full_o      = full;
  assign busy_o      = (state_q != IDLE);
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Randomised self-checking bench for uart_rx: drives 8N1 frames on the line and
// compares the FIFO/flag behaviour against a queue-based model.
module tb_uart_rx;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        rx_en_i;
  logic [15:0] baud_div_i;
  logic        rx_bit_i;
  logic        rx_re_i;
  logic [7:0]  dout_o;
  logic        empty_o, full_o, busy_o, frame_err_o, overrun_o;
  logic        err_clr_i;

  uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .rx_en_i(rx_en_i), .baud_div_i(baud_div_i),
    .rx_bit_i(rx_bit_i), .rx_re_i(rx_re_i), .dout_o(dout_o), .empty_o(empty_o),
    .full_o(full_o), .busy_o(busy_o), .frame_err_o(frame_err_o),
    .overrun_o(overrun_o), .err_clr_i(err_clr_i)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_total = 0, n_bad = 0;
  int          div;
  int          fall_cyc;
  logic [7:0]  exp_q[$];
  logic        exp_ovr, exp_ferr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  task automatic set_div(input int d);
    div = d;
    baud_div_i = 16'(d);
  endtask

  task automatic flag_checks(input string tag);
    check({tag, "_empty"}, empty_o, exp_q.size() == 0);
    check({tag, "_full"}, full_o, exp_q.size() == 16);
    check({tag, "_ovr"}, overrun_o, exp_ovr);
    check({tag, "_ferr"}, frame_err_o, exp_ferr);
    check({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // One full 10-bit frame; optional pop at cycle pop_at, optional rx_en drop mid-frame.
  task automatic send_frame(input logic [7:0] data, input logic stopb,
                            input int pop_at, input logic drop_en);
    logic [9:0] bits;
    logic       accept;
    bits     = {stopb, data, 1'b0};
    accept   = rx_en_i;
    fall_cyc = -1;
    for (int c = 0; c < 10 * div; c++) begin
      rx_bit_i = bits[c / div];
      if (drop_en && c == 3 * div) rx_en_i = 1'b0;
      if (c == pop_at && exp_q.size() > 0) begin
        check("pop_head", dout_o, exp_q[0]);
        void'(exp_q.pop_front());
        rx_re_i = 1'b1;
      end
      tick();
      rx_re_i = 1'b0;
      if (fall_cyc < 0 && !empty_o) fall_cyc = c + 1;
    end
    rx_bit_i = 1'b1;
    if (accept) begin
      if (!stopb)                exp_ferr = 1'b1;
      else if (exp_q.size() < 16) exp_q.push_back(data);
      else                       exp_ovr = 1'b1;
    end
    if (!stopb) repeat (div) tick();
    if (drop_en) rx_en_i = 1'b1;
  endtask

  task automatic pop();
    check("rd_data", dout_o, exp_q[0]);
    void'(exp_q.pop_front());
    rx_re_i = 1'b1;
    tick();
    rx_re_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    while (exp_q.size() > 0) pop();
    check({tag, "_drained"}, empty_o, 1'b1);
  endtask

  task automatic clr_err();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_ovr  = 1'b0;
    exp_ferr = 1'b0;
    check("clr_ferr", frame_err_o, 1'b0);
    check("clr_ovr", overrun_o, 1'b0);
  endtask

  initial begin
    logic [9:0] bits;
    rst_ni = 1'b0; rx_en_i = 1'b1; rx_bit_i = 1'b1; rx_re_i = 1'b0; err_clr_i = 1'b0;
    exp_ovr = 1'b0; exp_ferr = 1'b0;
    set_div(16);
    tick(); tick();
    check("rst_empty", empty_o, 1'b1);
    check("rst_full", full_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_ferr", frame_err_o, 1'b0);
    check("rst_ovr", overrun_o, 1'b0);
    check("rst_dout", dout_o, 8'h00);
    rst_ni = 1'b1;
    repeat (4) tick();

    // 1: single byte; head appears one cycle after the mid-stop sample
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    check("t1_latency", fall_cyc, 3 + div / 2 + 9 * div);
    check("t1_dout", dout_o, 8'hA5);
    flag_checks("t1");
    drain("t1");

    // 2: short low glitch is rejected at the start-bit check
    rx_bit_i = 1'b0;
    repeat (4) tick();
    rx_bit_i = 1'b1;
    check("t2_busy_start", busy_o, 1'b1);
    repeat (2 * div) tick();
    flag_checks("t2");

    // 3: bad stop bit
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    flag_checks("t3");
    clr_err();

    // 4: overfill without reads
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, -1, 1'b0);
    flag_checks("t4");
    drain("t4");
    clr_err();

    // rx_en: dropped mid-frame still completes; held low ignores the frame
    send_frame(8'h81, 1'b1, -1, 1'b1);
    flag_checks("en_drop");
    rx_en_i = 1'b0;
    send_frame(8'h42, 1'b1, -1, 1'b0);
    repeat (div) tick();
    rx_en_i = 1'b1;
    flag_checks("en_off");
    drain("en");

    // Push and pop in the same cycle while holding one entry
    send_frame(8'h11, 1'b1, -1, 1'b0);
    send_frame(8'h22, 1'b1, 2 + div / 2 + 9 * div, 1'b0);
    check("one_dout", dout_o, 8'h22);
    flag_checks("one");
    drain("one");

    // 5: 32 random back-to-back bytes at div 104, one read per frame
    set_div(104);
    for (int i = 0; i < 32; i++) send_frame(8'($urandom), 1'b1, 5 * div, 1'b0);
    flag_checks("t5a");
    drain("t5a");
    // fill, then a push coinciding with a pop while full
    for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, -1, 1'b0);
    send_frame(8'($urandom), 1'b1, 2 + div / 2 + 9 * div, 1'b0);
    flag_checks("t5b");
    drain("t5b");

    // Random divisors, bad stop bits and reads
    for (int b = 0; b < 4; b++) begin
      set_div($urandom_range(8, 40));
      for (int i = 0; i < 8; i++)
        send_frame(8'($urandom), ($urandom_range(0, 5) != 0),
                   ($urandom_range(0, 1) != 0) ? 5 * div : -1, 1'b0);
      flag_checks("rnd");
    end
    drain("rnd");
    clr_err();

    // 6: reset during data bit 3
    set_div(16);
    send_frame(8'h77, 1'b1, -1, 1'b0);
    send_frame(8'h01, 1'b0, -1, 1'b0);
    bits = {1'b1, 8'h5A, 1'b0};
    for (int c = 0; c < 4 * div + div / 2; c++) begin
      rx_bit_i = bits[c / div];
      tick();
    end
    check("t6_busy_pre", busy_o, 1'b1);
    rst_ni = 1'b0;
    rx_bit_i = 1'b1;
    #1;
    check("t6_empty", empty_o, 1'b1);
    check("t6_full", full_o, 1'b0);
    check("t6_busy", busy_o, 1'b0);
    check("t6_ferr", frame_err_o, 1'b0);
    check("t6_ovr", overrun_o, 1'b0);
    check("t6_dout", dout_o, 8'h00);
    exp_q.delete();
    exp_ferr = 1'b0;
    exp_ovr  = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    repeat (4) tick();
    send_frame(8'h5A, 1'b1, -1, 1'b0);
    check("t6_dout_5a", dout_o, 8'h5A);
    flag_checks("t6");
    drain("t6");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
